display_scan: RTL and testbench
===============================

DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter REFRESH_DIV, default 4: clock cycles per digit slot; legal range 1..65535.
REQ-003 Parameter BLINK_FRAMES, default 8: full scan frames per half-period of the separator blink.
REQ-004 clk  input  1  system clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high; clears all state.
REQ-006 digits  input  16  four BCD stopwatch digits; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
REQ-007 hold  input  1  lap freeze: while 1, the displayed snapshot SHALL NOT update.
REQ-008 lz_en  input  1  enables leading-zero blanking.
REQ-009 an  output  4  active-low digit enables, exactly one low at any time.
REQ-010 seg  output  7  active-low segments {g,f,e,d,c,b,a}.
REQ-011 dp  output  1  active-low separator point.

Function
REQ-012 Prescaler SHALL count 0..REFRESH_DIV-1 and wrap to 0. tick is asserted in the cycle the count equals REFRESH_DIV-1. With REFRESH_DIV=1, tick is asserted every cycle.
REQ-013 Digit index idx (2 bits) SHALL advance 0->1->2->3->0 on each tick.
REQ-014 Frame boundary = tick with idx==3. On a frame boundary with hold==0, snapshot SHALL load digits.
REQ-015 On a frame boundary with hold==1, snapshot SHALL keep its value. After hold falls, the first frame boundary SHALL capture.
REQ-016 an, seg and dp SHALL be registered from idx and snapshot, one cycle after idx changes. an = ~(1<<idx).
REQ-017 Decode (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Values 10..15 SHALL display dash 0111111.
REQ-018 Blanking with lz_en=1 (blanked slot drives seg=1111111; its an is still driven low):
- digit 3 is blanked when its value is 0;
- digit 2 is blanked when its value is 0 and digit 3 is blanked;
- digit 1 is blanked when its value is 0 and digit 2 is blanked;
- digit 0 is never blanked.
REQ-019 Blanking SHALL be evaluated on snapshot, not on live digits.
REQ-020 dp SHALL be low only in the slot where idx==2; in all other slots it is 1. dp is unaffected by blanking.

Reset
REQ-021 While reset is 1: prescaler=0, idx=0, snapshot=0, frame and blink counters=0.
REQ-022 Outputs after the reset edge: an=1110, seg=1000000, dp=1.
REQ-023 Reset asserted mid-frame SHALL abandon the frame. Reset SHALL override tick, hold and snapshot load in the same cycle.

Configuration
REQ-024 Macro DISPLAY_SCAN_BLINK_EN.
- Defined: a frame counter toggles a blink phase every BLINK_FRAMES frame boundaries, and dp in slot 2 SHALL follow the blink phase (low when the phase is 0).
- Undefined: no blink counter logic is present, and dp in slot 2 is steady low.

Structure
REQ-025 Package display_scan_pkg SHALL hold the segment pattern constants (SEG_0..SEG_9, SEG_DASH, SEG_OFF) and typedef digit_idx_t (2-bit).
REQ-026 Sub-module seg7_decode SHALL be the combinational 4-bit-to-7-segment decoder, instantiated once on the muxed snapshot digit.

Verification
REQ-027 Reset with REFRESH_DIV=4, then 16 cycles -> an sequence 1110,1101,1011,0111, each held 4 cycles; seg=1000000 in every slot.
REQ-028 digits=16'h1234 loaded before a frame boundary, lz_en=0 -> next frame shows:
- slot 0: seg=0011001 (4)
- slot 1: seg=0110000 (3)
- slot 2: seg=0100100 (2), dp=0
- slot 3: seg=1111001 (1)
REQ-029 Snapshot=16'h1234, hold=1, then digits change to 16'h5678 for 3 frames -> display remains 1234. hold released -> 5678 appears starting with the frame after the next boundary.
REQ-030 digits=16'h0007, lz_en=1 -> slots 3,2,1 show seg=1111111; slot 0 shows 1111000. With digits=16'h0407: slot 3 blank, slot 2 shows 4, slot 1 shows 0000 pattern 1000000.
REQ-031 digits=16'h00AF -> slots 0 and 1 show dash 0111111.
REQ-032 With DISPLAY_SCAN_BLINK_EN defined and BLINK_FRAMES=2 -> dp in slot 2 is low for 2 frames, then high for 2 frames, repeating. Reset asserted at cycle 5 of a frame -> next cycle an=1110, seg=1000000.

Source files
------------

// File: rtl/display_scan_pkg.sv
// Shared segment patterns (active-low {g,f,e,d,c,b,a}) and the digit slot index type
// for the display_scan block.
package display_scan_pkg;

  typedef logic [1:0] digit_idx_t;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  // Active-low anode pattern selecting one slot.
  function automatic logic [3:0] an_onehot_n(input digit_idx_t idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/display_scan_if.sv
// Display bus: stopwatch digits and controls in, multiplexed segment drive out.
interface display_scan_if;

  logic [15:0] digits;
  logic        hold;
  logic        lz_en;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  modport master (output digits, hold, lz_en, input an, seg, dp);
  modport slave  (input digits, hold, lz_en, output an, seg, dp);

endinterface

// File: rtl/display_scan_seg7_decode.sv
// Combinational BCD to active-low 7-segment decoder; non-decimal codes show a dash.
module seg7_decode
  import display_scan_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/display_scan.sv
// Four-digit multiplexed stopwatch display scanner with lap hold and leading-zero blanking.
// Define DISPLAY_SCAN_BLINK_EN to make the separator point blink every BLINK_FRAMES frames.
module display_scan
  import display_scan_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 4,
  parameter int unsigned BLINK_FRAMES = 8
) (
  input  logic           clk,
  input  logic           reset,
  display_scan_if.slave  bus
);

  if (REFRESH_DIV < 1 || REFRESH_DIV > 65535) begin : g_bad_div
    $error("display_scan: REFRESH_DIV must be in 1..65535");
  end
  if (BLINK_FRAMES < 1) begin : g_bad_blink
    $error("display_scan: BLINK_FRAMES must be at least 1");
  end

  localparam logic [15:0] DIV_LAST = 16'(REFRESH_DIV - 1);

  logic [15:0] r_presc;
  digit_idx_t  r_idx;
  logic [15:0] r_snap;
  logic [3:0]  r_an;
  logic [6:0]  r_seg;
  logic        r_dp;

  logic        w_tick;
  logic        w_frame;
  logic        w_phase;
  logic        w_blank;
  logic        w_z3;
  logic        w_z2;
  logic        w_z1;
  logic [3:0]  w_digit;
  logic [6:0]  w_dec_seg;
  logic [6:0]  w_seg_next;
  logic        w_dp_next;

  assign w_tick  = (r_presc == DIV_LAST);
  assign w_frame = w_tick && (r_idx == 2'd3);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc <= '0;
      r_idx   <= '0;
      r_snap  <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 16'd1;
      if (w_tick) begin
        r_idx <= r_idx + 2'd1;
      end
      if (w_frame && !bus.hold) begin
        r_snap <= bus.digits;
      end
    end
  end

`ifdef DISPLAY_SCAN_BLINK_EN
  localparam logic [15:0] BLINK_LAST = 16'(BLINK_FRAMES - 1);

  logic [15:0] r_frame_cnt;
  logic        r_phase;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (w_frame) begin
      if (r_frame_cnt == BLINK_LAST) begin
        r_frame_cnt <= '0;
        r_phase     <= ~r_phase;
      end else begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  assign w_phase = r_phase;
`else
  assign w_phase = 1'b0;
`endif

  assign w_digit = r_snap[{r_idx, 2'b00} +: 4];

  seg7_decode u_dec (
    .i_bcd (w_digit),
    .o_seg (w_dec_seg)
  );

  // Blanking cascades down from digit 3; digit 0 always shows.
  assign w_z3 = (r_snap[15:12] == 4'd0);
  assign w_z2 = w_z3 && (r_snap[11:8] == 4'd0);
  assign w_z1 = w_z2 && (r_snap[7:4] == 4'd0);

  always_comb begin
    w_blank = 1'b0;
    if (bus.lz_en) begin
      case (r_idx)
        2'd1:    w_blank = w_z1;
        2'd2:    w_blank = w_z2;
        2'd3:    w_blank = w_z3;
        default: w_blank = 1'b0;
      endcase
    end
  end

  assign w_seg_next = w_blank ? SEG_OFF : w_dec_seg;
  assign w_dp_next  = (r_idx == 2'd2) ? w_phase : 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_an  <= an_onehot_n(2'd0);
      r_seg <= SEG_0;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= an_onehot_n(r_idx);
      r_seg <= w_seg_next;
      r_dp  <= w_dp_next;
    end
  end

  assign bus.an  = r_an;
  assign bus.seg = r_seg;
  assign bus.dp  = r_dp;

endmodule

// File: tb/tb_display_scan.sv
// Self-checking bench for display_scan: cycle-count based reference model plus directed
// scenarios; a second instance with REFRESH_DIV=1 covers the every-cycle tick case.
module tb_display_scan;

  localparam int unsigned DIV   = 4;
  localparam int unsigned BF    = 2;
  localparam int unsigned FRAME = 4 * DIV;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  display_scan_if bus ();
  display_scan_if bus1 ();

  assign bus1.digits = bus.digits;
  assign bus1.hold   = bus.hold;
  assign bus1.lz_en  = bus.lz_en;

  display_scan #(.REFRESH_DIV(DIV), .BLINK_FRAMES(BF)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  display_scan #(.REFRESH_DIV(1), .BLINK_FRAMES(BF)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  always #5 clk = ~clk;

  // Segment patterns written out from the decode table of the display.
  logic [6:0] SEG_REF [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  function automatic logic [6:0] model_seg(input logic [15:0] s, input int unsigned slot,
                                           input logic lz);
    logic [15:0] upper;
    logic [3:0]  v;
    upper = s >> (4 * slot);
    v     = upper[3:0];
    if (lz && slot != 0 && upper == 16'h0000) return 7'b1111111;
    if (v > 4'd9) return 7'b0111111;
    return SEG_REF[v];
  endfunction

  // Reference model: k counts clock edges since reset; the outputs after edge k show
  // slot ((k-1)/DIV)%4 of the snapshot held before that edge.
  int unsigned k = 0;
  int unsigned m_frames = 0;
  int unsigned m_slot;
  int unsigned m_ph;
  logic [15:0] m_snap = '0;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic [3:0]  exp_an1;

  always @(posedge clk) begin
    if (reset) begin
      k = 0; m_frames = 0; m_snap = '0;
      exp_an = 4'b1110; exp_seg = 7'b1000000; exp_dp = 1'b1; exp_an1 = 4'b1110;
    end else begin
      k++;
      m_slot  = ((k - 1) / DIV) % 4;
      exp_an  = ~(4'b0001 << m_slot);
      exp_seg = model_seg(m_snap, m_slot, bus.lz_en);
`ifdef DISPLAY_SCAN_BLINK_EN
      m_ph = (m_frames / BF) % 2;
`else
      m_ph = 0;
`endif
      exp_dp  = (m_slot == 2) ? (m_ph != 0) : 1'b1;
      exp_an1 = ~(4'b0001 << ((k - 1) % 4));
      if (k % FRAME == 0) begin
        m_frames++;
        if (!bus.hold) m_snap = bus.digits;
      end
    end
  end

  task automatic sync_frame();
    int unsigned n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((k % FRAME) != 0 && n < 3 * FRAME);
    if ((k % FRAME) != 0) begin
      n_fail++;
      $display("FAIL sync_frame: no frame boundary within %0d cycles", n);
    end
  endtask

  task automatic test_reset();
    logic [3:0] want_an;
    reset = 1'b1; bus.digits = 16'h9876; bus.hold = 1'b0; bus.lz_en = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.an, bus.seg, bus.dp, bus1.an} !== {4'b1110, 7'b1000000, 1'b1, 4'b1110}) begin
      n_fail++;
      $display("FAIL reset_state: an/seg/dp/an1=%b/%b/%b/%b expected 1110/1000000/1/1110",
               bus.an, bus.seg, bus.dp, bus1.an);
    end
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      want_an = ~(4'b0001 << (i / 4));
      n_checks++;
      if (bus.an !== want_an || bus.seg !== 7'b1000000 || bus.dp !== (i / 4 != 2)) begin
        n_fail++;
        $display("FAIL reset_scan cyc%0d: an/seg/dp=%b/%b/%b expected %b/1000000/%b",
                 i, bus.an, bus.seg, bus.dp, want_an, (i / 4 != 2));
      end
    end
  endtask

  task automatic test_digits_1234();
    logic [6:0] want [4];
    want = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
    bus.digits = 16'h1234; bus.lz_en = 1'b0; bus.hold = 1'b0;
    sync_frame();
    for (int j = 0; j < FRAME; j++) begin
      @(negedge clk);
      n_checks++;
      if (bus.seg !== want[j / DIV] || bus.an !== exp_an || bus.dp !== exp_dp) begin
        n_fail++;
        $display("FAIL digits_1234 slot%0d: an/seg/dp=%b/%b/%b expected %b/%b/%b",
                 j / DIV, bus.an, bus.seg, bus.dp, exp_an, want[j / DIV], exp_dp);
      end
    end
  endtask

  task automatic test_hold();
    logic [6:0] old_v [4];
    logic [6:0] new_v [4];
    old_v = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
    new_v = '{7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010};
    bus.hold = 1'b1; bus.digits = 16'h5678;
    for (int j = 0; j < 3 * FRAME; j++) begin
      @(negedge clk);
      n_checks++;
      if (bus.seg !== old_v[(j % FRAME) / DIV] || bus.an !== exp_an) begin
        n_fail++;
        $display("FAIL hold_frozen cyc%0d: an/seg=%b/%b expected %b/%b",
                 j, bus.an, bus.seg, exp_an, old_v[(j % FRAME) / DIV]);
      end
    end
    bus.hold = 1'b0;
    sync_frame();
    for (int j = 0; j < FRAME; j++) begin
      @(negedge clk);
      n_checks++;
      if (bus.seg !== new_v[j / DIV] || bus.an !== exp_an) begin
        n_fail++;
        $display("FAIL hold_release slot%0d: an/seg=%b/%b expected %b/%b",
                 j / DIV, bus.an, bus.seg, exp_an, new_v[j / DIV]);
      end
    end
  endtask

  task automatic test_blank();
    logic [6:0] want_a [4];
    logic [6:0] want_b [4];
    want_a = '{7'b1111000, 7'b1111111, 7'b1111111, 7'b1111111};
    want_b = '{7'b1111000, 7'b1000000, 7'b0011001, 7'b1111111};
    bus.lz_en = 1'b1; bus.digits = 16'h0007;
    sync_frame();
    for (int j = 0; j < FRAME; j++) begin
      @(negedge clk);
      n_checks++;
      if (bus.seg !== want_a[j / DIV] || bus.an !== exp_an || bus.dp !== exp_dp) begin
        n_fail++;
        $display("FAIL blank_0007 slot%0d: an/seg/dp=%b/%b/%b expected %b/%b/%b",
                 j / DIV, bus.an, bus.seg, bus.dp, exp_an, want_a[j / DIV], exp_dp);
      end
    end
    bus.digits = 16'h0407;
    sync_frame();
    for (int j = 0; j < FRAME; j++) begin
      @(negedge clk);
      n_checks++;
      if (bus.seg !== want_b[j / DIV] || bus.an !== exp_an) begin
        n_fail++;
        $display("FAIL blank_0407 slot%0d: an/seg=%b/%b expected %b/%b",
                 j / DIV, bus.an, bus.seg, exp_an, want_b[j / DIV]);
      end
    end
  endtask

  task automatic test_dash();
    logic [6:0] want [4];
    want = '{7'b0111111, 7'b0111111, 7'b1000000, 7'b1000000};
    bus.lz_en = 1'b0; bus.digits = 16'h00AF;
    sync_frame();
    for (int j = 0; j < FRAME; j++) begin
      @(negedge clk);
      n_checks++;
      if (bus.seg !== want[j / DIV] || bus.an !== exp_an) begin
        n_fail++;
        $display("FAIL dash_00AF slot%0d: an/seg=%b/%b expected %b/%b",
                 j / DIV, bus.an, bus.seg, exp_an, want[j / DIV]);
      end
    end
  endtask

  task automatic test_dp();
    int unsigned slot;
    int unsigned f;
    logic want;
    reset = 1'b1; bus.digits = 16'h0000; bus.lz_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int j = 0; j < 5 * FRAME; j++) begin
      @(negedge clk);
      slot = (j % FRAME) / DIV;
      f    = j / FRAME;
`ifdef DISPLAY_SCAN_BLINK_EN
      want = (slot == 2) ? (((f / BF) % 2) != 0) : 1'b1;
`else
      want = (slot == 2) ? 1'b0 : 1'b1;
`endif
      n_checks++;
      if (bus.dp !== want || bus.an !== ~(4'b0001 << slot)) begin
        n_fail++;
        $display("FAIL dp_blink frame%0d slot%0d: dp/an=%b/%b expected %b/%b",
                 f, slot, bus.dp, bus.an, want, ~(4'b0001 << slot));
      end
    end
  endtask

  task automatic test_reset_midframe();
    bus.digits = 16'h9999; bus.hold = 1'b0; bus.lz_en = 1'b0;
    sync_frame();
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({bus.an, bus.seg, bus.dp} !== {4'b1110, 7'b1000000, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_midframe: an/seg/dp=%b/%b/%b expected 1110/1000000/1",
               bus.an, bus.seg, bus.dp);
    end
    reset = 1'b0;
    sync_frame();
    for (int j = 0; j < FRAME - 1; j++) begin
      @(negedge clk);
      n_checks++;
      if (bus.seg !== 7'b0010000 || bus.an !== exp_an) begin
        n_fail++;
        $display("FAIL pre_boundary cyc%0d: an/seg=%b/%b expected %b/0010000",
                 j, bus.an, bus.seg, exp_an);
      end
    end
    // Next edge would be a frame boundary loading 0x1111; reset must win.
    bus.digits = 16'h1111;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int j = 0; j < FRAME; j++) begin
      @(negedge clk);
      n_checks++;
      if (bus.seg !== 7'b1000000 || bus.an !== ~(4'b0001 << (j / DIV))) begin
        n_fail++;
        $display("FAIL reset_over_load cyc%0d: an/seg=%b/%b expected %b/1000000",
                 j, bus.an, bus.seg, ~(4'b0001 << (j / DIV)));
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] v;
    logic [3:0]  nib;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.an, bus.seg, bus.dp, bus1.an} !== {exp_an, exp_seg, exp_dp, exp_an1}) begin
        n_fail++;
        $display("FAIL random cyc%0d k=%0d: an/seg/dp/an1=%b/%b/%b/%b expected %b/%b/%b/%b",
                 i, k, bus.an, bus.seg, bus.dp, bus1.an, exp_an, exp_seg, exp_dp, exp_an1);
      end
      if ($urandom_range(0, 7) == 0) begin
        for (int d = 0; d < 4; d++) begin
          case ($urandom_range(0, 3))
            0:       nib = 4'd0;
            1, 2:    nib = 4'($urandom_range(0, 9));
            default: nib = 4'($urandom_range(10, 15));
          endcase
          v[4 * d +: 4] = nib;
        end
        bus.digits = v;
      end
      if ($urandom_range(0, 15) == 0) bus.hold = ~bus.hold;
      if ($urandom_range(0, 31) == 0) bus.lz_en = ~bus.lz_en;
      reset = ($urandom_range(0, 249) == 0);
    end
    reset = 1'b0;
  endtask

  initial begin
    bus.digits = '0; bus.hold = 1'b0; bus.lz_en = 1'b0;
    test_reset();
    test_digits_1234();
    test_hold();
    test_blank();
    test_dash();
    test_dp();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
